// File: rtl/qsys_led_master_0_rsp_timing_adt.sv
// Response-timing adapter: accepts beats with readyLatency 0 upstream and replays
// them downstream with readyLatency 1 through a small circular buffer.
module qsys_led_master_0_rsp_timing_adt #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_FULL = (AW + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              r_ready_d;
    logic              w_push;
    logic              w_pop;
    logic              w_empty;

    // Handshake decode uses only registered state, so out_ready never reaches in_ready.
    always_comb begin
        w_empty   = (r_count == {(AW + 1){1'b0}});
        in_ready  = reset_n & (r_count != C_FULL);
        out_valid = reset_n & r_ready_d & ~w_empty;
        w_push    = in_valid & in_ready;
        w_pop     = out_valid;
        if (out_valid) begin
            out_data = r_mem[r_rd_ptr];
        end else begin
            out_data = {DATA_W{1'b0}};
        end
    end

    // Pointer, occupancy and delayed-ready state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr  <= {AW{1'b0}};
            r_rd_ptr  <= {AW{1'b0}};
            r_count   <= {(AW + 1){1'b0}};
            r_ready_d <= 1'b0;
        end else begin
            r_ready_d <= out_ready;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Buffer storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end else begin
            r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
        end
    end

endmodule

// File: tb/tb_qsys_led_master_0_rsp_timing_adt.sv
// Scoreboard bench: accepted beats queue up in order; a monitor checks handshakes
// and payloads against a queue-based model of the buffer.
module tb_qsys_led_master_0_rsp_timing_adt;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    logic [DATA_W-1:0] sb [$];
    int                vectors     = 0;
    int                miscompares = 0;
    bit                prev_ready  = 1'b0;

    always #5 clk = ~clk;

    qsys_led_master_0_rsp_timing_adt #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic v, input logic [DATA_W-1:0] d, input logic r);
        @(posedge clk);
        #1;
        reset_n   = rst;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
    endtask

    // Every beat the upstream hands over is expected downstream in the same order.
    always @(negedge clk) begin
        #2;
        if (reset_n === 1'b1 && in_valid === 1'b1 && in_ready === 1'b1) begin
            sb.push_back(in_data);
        end
    end

    // Monitor: occupancy is the queue length, ready_d is last cycle's out_ready.
    always @(negedge clk) begin
        logic [DATA_W-1:0] exp_d;
        if (reset_n !== 1'b1) begin
            check("rst_in_ready", 32'(in_ready), 32'd0);
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_out_data", 32'(out_data), 32'd0);
            sb.delete();
            prev_ready = 1'b0;
        end else begin
            check("in_ready", 32'(in_ready), 32'(sb.size() != DEPTH));
            check("out_valid", 32'(out_valid), 32'(prev_ready && sb.size() != 0));
            if (out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check("out_data_unexpected", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    exp_d = sb.pop_front();
                    check("out_data", 32'(out_data), 32'(exp_d));
                end
            end else begin
                check("out_data_idle", 32'(out_data), 32'd0);
            end
            prev_ready = out_ready;
        end
    end

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        repeat (3) step(1'b0, 1'b0, 8'h00, 1'b0);

        // single beat, one-cycle latency
        step(1'b1, 1'b1, 8'hA5, 1'b1);
        repeat (3) step(1'b1, 1'b0, 8'h00, 1'b1);
        repeat (2) step(1'b1, 1'b0, 8'h00, 1'b0);

        // fill while stalled, fifth beat held, then release
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, 8'(i), 1'b0);
        repeat (3) step(1'b1, 1'b1, 8'h05, 1'b0);
        repeat (7) step(1'b1, 1'b0, 8'h00, 1'b1);

        // full buffer with toggling out_ready
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'h30 + 8'(i), 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'h00, 1'(i % 2 == 0));
        repeat (6) step(1'b1, 1'b0, 8'h00, 1'b1);

        // simultaneous push and pop with a single entry
        step(1'b1, 1'b1, 8'h10, 1'b1);
        step(1'b1, 1'b1, 8'h20, 1'b1);
        repeat (3) step(1'b1, 1'b0, 8'h00, 1'b1);

        // random traffic well past pointer wrap
        for (int i = 0; i < 24 * DEPTH; i++) begin
            step(1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
        end
        repeat (8) step(1'b1, 1'b0, 8'h00, 1'b1);

        // reset with three beats buffered; they must never appear
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'h41 + 8'(i), 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        repeat (6) step(1'b1, 1'b0, 8'h00, 1'b1);

        @(negedge clk);
        #3;
        check("drain_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/qsys_led_master_0_rsp_timing_adt.md
QSYS_LED_MASTER_0_RSP_TIMING_ADT -- requirements
Module: qsys_led_master_0_rsp_timing_adt

Interface
REQ-001 Parameter DATA_W, default 8: payload width in bits.
REQ-002 Parameter DEPTH, default 4: buffer entries; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  reset, synchronous and active-low.
REQ-005 in_valid  input  1  upstream beat valid (readyLatency 0).
REQ-006 in_data  input  DATA_W  upstream payload.
REQ-007 in_ready  output  1  block can accept a beat this cycle.
REQ-008 out_valid  output  1  downstream beat valid (readyLatency 1).
REQ-009 out_data  output  DATA_W  downstream payload.
REQ-010 out_ready  input  1  downstream ready; qualifies out_valid in the following cycle.

Function
REQ-011 The block SHALL hold a circular buffer of DEPTH entries, with write pointer wr_ptr, read pointer rd_ptr (log2(DEPTH) bits each, wrapping DEPTH-1 -> 0) and occupancy count (0..DEPTH, log2(DEPTH)+1 bits).
REQ-012 in_ready SHALL be 1 iff reset_n=1 and count != DEPTH, decoded from registered count only (no combinational path from out_ready).
REQ-013 Push SHALL occur when in_valid=1 and in_ready=1: mem[wr_ptr] <= in_data; wr_ptr increments.
REQ-014 in_valid=1 with in_ready=0 SHALL leave all state unchanged; upstream holds the beat.
REQ-015 Register ready_d <= out_ready every cycle.
REQ-016 out_valid SHALL be 1 iff ready_d=1 and count != 0; it never asserts in a cycle following out_ready=0.
REQ-017 out_data SHALL equal mem[rd_ptr] when out_valid=1, and all-zeros when out_valid=0.
REQ-018 Pop SHALL occur on every cycle with out_valid=1 (no further acceptance check); rd_ptr increments.
REQ-019 count SHALL be +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop or neither.
REQ-020 Simultaneous push and pop with count=1 SHALL output the old head and store the new beat, leaving count=1.
REQ-021 Minimum latency SHALL be 1 cycle: a beat pushed in cycle N can appear on out_valid no earlier than cycle N+1, provided out_ready=1 in cycle N.
REQ-022 Order SHALL be strictly FIFO; no beat is dropped or duplicated.
REQ-023 Sustained throughput SHALL be 1 beat per cycle while in_valid=1 and out_ready is held at 1.

Reset
REQ-024 While reset_n=0 at a clock edge: wr_ptr, rd_ptr and count SHALL go to 0, and ready_d SHALL go to 0.
REQ-025 During reset, outputs SHALL be in_ready=0, out_valid=0 and out_data=0; buffer contents are not reset.
REQ-026 Reset asserted mid-stream SHALL discard all buffered beats; the first cycle after release SHALL show in_ready=1 and out_valid=0.

Verification
REQ-027 Reset, then in_valid=1 with in_data=8'hA5 in cycle 0 and out_ready=1 held from cycle 0 -> out_valid=1 and out_data=8'hA5 in cycle 1 only.
REQ-028 out_ready=0 held; push 8'h01..8'h04 -> in_ready=0 after the 4th push and a 5th beat is stalled; then out_ready=1 -> outputs 01, 02, 03, 04 on 4 consecutive cycles starting 1 cycle after out_ready rises.
REQ-029 out_ready toggling 1,0,1,0 with a full buffer -> out_valid pattern lags out_ready by exactly 1 cycle; data stays in order with none lost.
REQ-030 count=1 (head 8'h10), push 8'h20 with ready_d=1 in the same cycle -> 8'h10 is output, count stays 1, and 8'h20 is output next if ready_d=1.
REQ-031 Wrap: 3 x DEPTH random beats with random in_valid and out_ready -> scoreboard matches in order, and out_valid never asserts after out_ready=0.
REQ-032 Reset pulsed with count=3 -> the cycle after release shows count=0, in_ready=1 and out_valid=0, and the stale beats are never emitted.
